stage_fetch: RTL
================

Name: stage_fetch

Overview:
- Instruction fetch stage plus F/D pipeline latch. It feeds the decode stage directly.
- Owns the PC and drives the synchronous instruction ROM.
- Latches the returned instruction and presents pre-split fields (opcode, rd, rs, rt, ALU_op) to decode.
- Supports hazard stall, and redirect/flush from the execute stage.

Parameters:
- ADDR_WIDTH, 12: PC and imem address width in words; PC wraps modulo 2^ADDR_WIDTH.
- INSN_WIDTH, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset.
- NOP_INSN, 32'h00000000: instruction injected on flush/reset (add $0,$0,$0).

Ports:
- clock  in  1  Single clock; all state updates on rising edge.
- reset  in  1  Synchronous, active-high.
- stall  in  1  Hazard stall from the hazard unit; freezes PC and F/D latch.
- redirect  in  1  Taken branch/jump resolved in execute.
- redirect_target  in  ADDR_WIDTH  New PC when redirect=1.
- address_imem  out  ADDR_WIDTH  Address to sync ROM; combinational from pc_next.
- q_imem  in  INSN_WIDTH  ROM data; corresponds to the address latched at the previous edge.
- pc_out  out  ADDR_WIDTH  Current fetch PC (pc_reg).
- fd_insn  out  INSN_WIDTH  Latched instruction.
- fd_pc  out  ADDR_WIDTH  PC of fd_insn.
- fd_pc_plus1  out  ADDR_WIDTH  fd_pc+1 (wrapped), used for branch/jal.
- fd_valid  out  1  fd_insn is a real instruction, not a bubble.
- fd_opcode  out  5  fd_insn[31:27].
- fd_rd  out  5  fd_insn[26:22].
- fd_rs  out  5  fd_insn[21:17].
- fd_rt  out  5  fd_insn[16:12].
- fd_ALU_op  out  5  fd_insn[6:2].

Behaviour:
- Invariant: q_imem in cycle N is mem[pc_reg], because the ROM registered address_imem=pc_next at the previous edge.
- pc_next priority (combinational):
  - reset: RESET_PC
  - else redirect: redirect_target
  - else stall: pc_reg
  - else pc_reg+1, truncated to ADDR_WIDTH; wraps 2^ADDR_WIDTH-1 -> 0.
- address_imem = pc_next at all times, including during reset, so mem[RESET_PC] is ready in the first cycle after reset.
- pc_reg <= pc_next every edge.
- F/D latch update priority at each edge:
  - reset: fd_insn=NOP_INSN, fd_pc=RESET_PC, fd_valid=0.
  - redirect (overrides stall): fd_insn=NOP_INSN, fd_valid=0, fd_pc=pc_reg. This squashes the wrong-path instruction.
  - stall: all fd_* hold.
  - normal: fd_insn<=q_imem, fd_pc<=pc_reg, fd_valid<=1.
- Reset values: pc_out=RESET_PC, fd_insn=0, fd_pc=RESET_PC, fd_pc_plus1=RESET_PC+1, fd_valid=0, all field outputs 0.
- Latency:
  - First real instruction at fd_* with fd_valid=1 two cycles after reset deasserts: cycle 1 fetch, latched at the cycle 1->2 edge.
  - Redirect penalty is exactly 1 bubble in this stage. Execute flushes its own D/X latch separately.
- Field outputs are pure slices of fd_insn, so a bubble presents opcode 0, rd/rs/rt 0 and is harmless to decode.
- Simultaneous stall+redirect: redirect wins; PC takes target, F/D is flushed.
- Redirect to the current pc_reg is legal: refetch.
- Reset mid-operation: full reinit next edge, regardless of stall/redirect.
- No X propagation: every register is reset.

Decomposition:
- Shared package/header defines:
  - Field bit positions: OPC_MSB/LSB 31:27, RD 26:22, RS 21:17, RT 16:12, SHAMT 11:7, ALUOP 6:2.
  - NOP_INSN, OPC_RTYPE=5'b00000.
  - These are the same constants decode uses to select rt vs rd.
- One sub-module, insn_fields, does the combinational field split. Decode and later stages reuse it.
- PC register and F/D latch live in stage_fetch itself.

Test Plan:
- Reset then run, ROM mem[i]=32'h1000_0000+i, no stall/redirect:
  - cycle 2: fd_insn=32'h1000_0000, fd_pc=0, fd_valid=1.
  - cycle 3: fd_pc=1.
  - address_imem increments each cycle.
- Stall held 3 cycles at pc_reg=5: pc_out stays 5, fd_* frozen at pc 4. After release, fd_pc=5 next edge with no skipped or duplicated PC.
- Redirect=1, target=12'h040, at pc_reg=7: next cycle fd_valid=0, fd_insn=0, pc_out=12'h040. Following cycle fd_pc=12'h040, fd_insn=mem[64].
- Redirect and stall both 1: behaves exactly as redirect alone (PC=target, bubble).
- Wrap: redirect to 12'hFFF then run: fd_pc sequence FFF, 000, 001; fd_pc_plus1 at FFF is 000.
- Reset asserted mid-stream with stall=1: next edge pc_out=0, fd_valid=0. mem[0] appears at fd two cycles after deassert.
- Field check: mem[0]=32'b00000_00011_00010_00001_00000_00000_00 gives fd_opcode=0, fd_rd=3, fd_rs=2, fd_rt=1, fd_ALU_op=0.

Source files
------------

// File: rtl/stage_fetch_pkg.sv
// Shared instruction-format constants for fetch, decode and later stages.
package stage_fetch_pkg;

  localparam int unsigned FIELD_W   = 5;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 27;
  localparam int unsigned RD_MSB    = 26;
  localparam int unsigned RD_LSB    = 22;
  localparam int unsigned RS_MSB    = 21;
  localparam int unsigned RS_LSB    = 17;
  localparam int unsigned RT_MSB    = 16;
  localparam int unsigned RT_LSB    = 12;
  localparam int unsigned SHAMT_MSB = 11;
  localparam int unsigned SHAMT_LSB = 7;
  localparam int unsigned ALUOP_MSB = 6;
  localparam int unsigned ALUOP_LSB = 2;

  // add $0,$0,$0 -- harmless bubble for every downstream stage
  localparam logic [31:0] NOP_INSN  = 32'h0000_0000;
  localparam logic [4:0]  OPC_RTYPE = 5'b00000;

  typedef logic [FIELD_W-1:0] field_t;

  // Decode uses this to choose rt vs rd as the destination register
  function automatic logic is_rtype(input field_t opc);
    return opc == OPC_RTYPE;
  endfunction

endpackage

// File: rtl/stage_fetch_insn_fields.sv
// Combinational split of an instruction word into its named fields.
module insn_fields
  import stage_fetch_pkg::*;
#(
  parameter int unsigned INSN_WIDTH = 32
) (
  input  logic [INSN_WIDTH-1:0] insn_i,
  output field_t                opcode_o,
  output field_t                rd_o,
  output field_t                rs_o,
  output field_t                rt_o,
  output field_t                alu_op_o
);

  // shamt and the two low bits are not consumed at this boundary
  logic unused_bits;
  assign unused_bits = ^{insn_i[SHAMT_MSB:SHAMT_LSB], insn_i[ALUOP_LSB-1:0]};

  assign opcode_o = insn_i[OPC_MSB:OPC_LSB];
  assign rd_o     = insn_i[RD_MSB:RD_LSB];
  assign rs_o     = insn_i[RS_MSB:RS_LSB];
  assign rt_o     = insn_i[RT_MSB:RT_LSB];
  assign alu_op_o = insn_i[ALUOP_MSB:ALUOP_LSB];

endmodule

// File: rtl/stage_fetch.sv
// Instruction fetch stage: PC register, sync-ROM addressing and F/D latch.
module stage_fetch #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           INSN_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN   = stage_fetch_pkg::NOP_INSN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic [ADDR_WIDTH-1:0] address_imem,
  input  logic [INSN_WIDTH-1:0] q_imem,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [INSN_WIDTH-1:0] fd_insn,
  output logic [ADDR_WIDTH-1:0] fd_pc,
  output logic [ADDR_WIDTH-1:0] fd_pc_plus1,
  output logic                  fd_valid,
  output logic [4:0]            fd_opcode,
  output logic [4:0]            fd_rd,
  output logic [4:0]            fd_rs,
  output logic [4:0]            fd_rt,
  output logic [4:0]            fd_ALU_op
);

  import stage_fetch_pkg::*;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INSN_WIDTH-1:0] fd_insn_q;
  logic [ADDR_WIDTH-1:0] fd_pc_q;
  logic                  fd_valid_q;

  // Next PC: reset > redirect > stall > sequential (wraps naturally)
  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(1);
    if (reset)         pc_d = RESET_PC;
    else if (redirect) pc_d = redirect_target;
    else if (stall)    pc_d = pc_q;
  end

  // The ROM registers pc_d, so its data next cycle always matches pc_q
  assign address_imem = pc_d;

  // PC register and F/D latch; redirect squashes the wrong-path fetch
  always_ff @(posedge clock) begin
    pc_q <= pc_d;
    if (reset) begin
      fd_insn_q  <= NOP_INSN;
      fd_pc_q    <= RESET_PC;
      fd_valid_q <= 1'b0;
    end else if (redirect) begin
      fd_insn_q  <= NOP_INSN;
      fd_pc_q    <= pc_q;
      fd_valid_q <= 1'b0;
    end else if (!stall) begin
      fd_insn_q  <= q_imem;
      fd_pc_q    <= pc_q;
      fd_valid_q <= 1'b1;
    end
  end

  assign pc_out      = pc_q;
  assign fd_insn     = fd_insn_q;
  assign fd_pc       = fd_pc_q;
  assign fd_pc_plus1 = fd_pc_q + ADDR_WIDTH'(1);
  assign fd_valid    = fd_valid_q;

  insn_fields #(
    .INSN_WIDTH (INSN_WIDTH)
  ) u_fields (
    .insn_i   (fd_insn_q),
    .opcode_o (fd_opcode),
    .rd_o     (fd_rd),
    .rs_o     (fd_rs),
    .rt_o     (fd_rt),
    .alu_op_o (fd_ALU_op)
  );

endmodule
